serial_frame_rx: RTL and testbench

//  Receive end of the serial link: deserialises the bit stream shifted out MSB-first by the

---
 rtl/serial_link_pkg.sv | 21 ++
 rtl/serial_frame_rx_if.sv | 34 +++
 rtl/sipo_shift_reg.sv | 33 +++
 rtl/serial_frame_rx.sv | 202 ++++++++++++++++++++
 tb/tb_serial_frame_rx.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// -----------------------------------------------------------------------------
// serial_link_pkg
//   Definitions shared by both ends of the serial link.
//   - frame_state_t : frame-level states used by the receiver
//   - IDLE_LEVEL    : line level between frames and for the stop bit
//   - START_LEVEL   : line level of the start bit
// -----------------------------------------------------------------------------
package serial_link_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4
  } frame_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_rx_if.sv
// -----------------------------------------------------------------------------
// serial_frame_rx_if
//   Signal bundle between the serial receiver and its environment.
//   master : the receiver (samples sdi/rx_ready/ovr_clr, drives the word port
//            and the status flags)
//   slave  : the environment (drives the line and the consumer handshake)
//   Signals: sdi, rx_ready, ovr_clr, rx_data[DATA_W], rx_valid, par_err,
//            frm_err, overrun, busy
// -----------------------------------------------------------------------------
interface serial_frame_rx_if #(
  parameter int DATA_W = 4
);

  logic              sdi;
  logic              rx_ready;
  logic              ovr_clr;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              par_err;
  logic              frm_err;
  logic              overrun;
  logic              busy;

  modport master (
    input  sdi, rx_ready, ovr_clr,
    output rx_data, rx_valid, par_err, frm_err, overrun, busy
  );

  modport slave (
    output sdi, rx_ready, ovr_clr,
    input  rx_data, rx_valid, par_err, frm_err, overrun, busy
  );

endinterface

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
//   Serial-in / parallel-out shift register. New bits enter at the LSB, so the
//   first bit shifted in ends up at the MSB after W shifts.
//   Ports: clk (rising edge), clr (async clear, active-high),
//          shift_en (shift this cycle), sdi (serial in), q[W] (parallel out)
// -----------------------------------------------------------------------------
module sipo_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         sdi,
  output logic [W-1:0] q
);

  logic [W-1:0] sr_r;

  // shift storage: clear asynchronously, shift in one bit when enabled
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr_r <= {W{1'b0}};
    end else if (shift_en) begin
      sr_r <= {sr_r[W-2:0], sdi};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign q = sr_r;

endmodule

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//   Receive end of the serial link. Deserialises an MSB-first frame
//   (start, DATA_W data bits, optional parity, stop) at one bit per clock,
//   checks parity and stop, and offers the word on a valid/ready port.
//   Ports: clk (rising edge), clr (async reset, active-high),
//          bus (serial_frame_rx_if.master):
//            sdi in, rx_ready in, ovr_clr in,
//            rx_data out, rx_valid out, par_err out, frm_err out (pulse),
//            overrun out (sticky), busy out
// -----------------------------------------------------------------------------
module serial_frame_rx
  import serial_link_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                clk,
  input  logic                clr,
  serial_frame_rx_if.master   bus
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  frame_state_t      state_r;
  frame_state_t      state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] sr_s;
  logic              perr_r;

  logic              shift_en_s;
  logic              cnt_clr_s;
  logic              par_sample_s;
  logic              deliver_s;
  logic              frame_bad_s;

  logic              take_s;
  logic              accept_s;
  logic              drop_s;

  logic [DATA_W-1:0] rx_data_r;
  logic              rx_valid_r;
  logic              par_err_r;
  logic              frm_err_r;
  logic              overrun_r;
  logic              busy_r;

  // 1 when data plus received parity bit disagree with the configured parity
  function automatic logic par_mismatch(input logic [DATA_W-1:0] d, input logic p);
    return (((^d) ^ p) != PARITY_ODD);
  endfunction

  sipo_shift_reg #(.W(DATA_W)) u_sipo (
    .clk      (clk),
    .clr      (clr),
    .shift_en (shift_en_s),
    .sdi      (bus.sdi),
    .q        (sr_s)
  );

  // frame state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= WAIT_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state logic; start detection in IDLE is level based, so a stop bit
  // followed directly by a start bit begins the next frame without a gap
  always_comb begin
    state_s = state_r;
    case (state_r)
      WAIT_IDLE: begin
        if (bus.sdi == IDLE_LEVEL) state_s = IDLE;
        else                       state_s = WAIT_IDLE;
      end
      IDLE: begin
        if (bus.sdi == START_LEVEL) state_s = DATA;
        else                        state_s = IDLE;
      end
      DATA: begin
        if (cnt_r != LAST_BIT) state_s = DATA;
        else if (PARITY_EN)    state_s = PARITY;
        else                   state_s = STOP;
      end
      PARITY: begin
        state_s = STOP;
      end
      STOP: begin
        // a low stop bit means we are out of step: wait for the line to idle
        if (bus.sdi == IDLE_LEVEL) state_s = IDLE;
        else                       state_s = WAIT_IDLE;
      end
      default: begin
        state_s = WAIT_IDLE;
      end
    endcase
  end

  // per-state control strobes
  always_comb begin
    shift_en_s   = 1'b0;
    cnt_clr_s    = 1'b0;
    par_sample_s = 1'b0;
    deliver_s    = 1'b0;
    frame_bad_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.sdi == START_LEVEL) cnt_clr_s = 1'b1;
        else                        cnt_clr_s = 1'b0;
      end
      DATA: begin
        shift_en_s = 1'b1;
      end
      PARITY: begin
        par_sample_s = 1'b1;
      end
      STOP: begin
        if (bus.sdi == IDLE_LEVEL) deliver_s   = 1'b1;
        else                       frame_bad_s = 1'b1;
      end
      default: begin
        shift_en_s = 1'b0;
      end
    endcase
  end

  // data bit counter, restarted by each start bit
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (shift_en_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // parity status of the frame in flight; the shift register already holds
  // every data bit while the parity bit is on the line
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      perr_r <= 1'b0;
    end else if (par_sample_s) begin
      perr_r <= par_mismatch(sr_s, bus.sdi);
    end else begin
      perr_r <= perr_r;
    end
  end

  // a held word leaves the slot when consumed; a new word may replace it in
  // the same cycle, otherwise a new word arriving at a full slot is dropped
  assign take_s   = rx_valid_r & bus.rx_ready;
  assign accept_s = deliver_s & (~rx_valid_r | bus.rx_ready);
  assign drop_s   = deliver_s & rx_valid_r & ~bus.rx_ready;

  // output word slot and status flags
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx_data_r  <= {DATA_W{1'b0}};
      rx_valid_r <= 1'b0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      overrun_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (accept_s) begin
        rx_data_r  <= sr_s;
        par_err_r  <= perr_r & PARITY_EN;
        rx_valid_r <= 1'b1;
      end else if (take_s) begin
        rx_valid_r <= 1'b0;
      end else begin
        rx_valid_r <= rx_valid_r;
      end
      // setting wins over a simultaneous clear request
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (bus.ovr_clr) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      frm_err_r <= frame_bad_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.par_err  = par_err_r;
  assign bus.frm_err  = frm_err_r;
  assign bus.overrun  = overrun_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//   Randomised and directed frames into serial_frame_rx (DATA_W=8, even parity)
//   plus a parity-less instance. A one-word slot model predicts which words
//   reach the port; delivered words go to a scoreboard queue that a separate
//   monitor drains on every observed handshake.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  serial_frame_rx_if #(.DATA_W(8)) bus  ();
  serial_frame_rx_if #(.DATA_W(8)) bus2 ();

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut2 (
    .clk (clk),
    .clr (clr),
    .bus (bus2)
  );

  int         n_checks = 0;
  int         n_fail   = 0;

  // scoreboard: {par_err, data} of every word the slot accepted
  logic [8:0] exp_q[$];

  // stimulus -> model side channel, valid for the edge ahead
  logic       deliver_now;
  logic       frm_now;
  logic [7:0] dlv_data;
  logic       dlv_perr;
  int         rdy_mode;
  logic       ovr_rand;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rnd_oc();
    return ovr_rand && ($urandom_range(0, 15) == 0);
  endfunction

  // one line bit, driven shortly after the rising edge
  task automatic bit_cycle(input logic b, input logic dlv, input logic fe,
                           input logic [7:0] dd, input logic dp,
                           input int rforce, input logic oc);
    @(posedge clk);
    #2;
    bus.sdi     = b;
    deliver_now = dlv;
    frm_now     = fe;
    dlv_data    = dd;
    dlv_perr    = dp;
    bus.ovr_clr = oc;
    if (rforce >= 0)        bus.rx_ready = rforce[0];
    else if (rdy_mode == 2) bus.rx_ready = 1'($urandom_range(0, 1));
    else                    bus.rx_ready = rdy_mode[0];
  endtask

  task automatic idle(input int n, input logic b);
    for (int k = 0; k < n; k++) bit_cycle(b, 1'b0, 1'b0, 8'h00, 1'b0, -1, rnd_oc());
  endtask

  // full frame; perr is what even parity makes of data plus the sent bit
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb, input int stop_rdy);
    logic perr;
    perr = ^{d, pbit};
    bit_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, -1, rnd_oc());
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(d[i], 1'b0, 1'b0, 8'h00, 1'b0, -1, rnd_oc());
      if (i == 4) check("busy_in_frame", 32'(bus.busy), 32'd1);
    end
    bit_cycle(pbit, 1'b0, 1'b0, 8'h00, 1'b0, -1, rnd_oc());
    bit_cycle(stopb, stopb, ~stopb, d, perr, stop_rdy, rnd_oc());
  endtask

  task automatic drain();
    rdy_mode = 1;
    idle(2, 1'b1);
    rdy_mode = 0;
  endtask

  // reference model: a single holding slot, overrun flag and error pulse
  initial begin : model
    int   slot_n;
    logic m_ovr;
    logic m_frm;
    logic ovr_set;
    slot_n = 0;
    m_ovr  = 1'b0;
    m_frm  = 1'b0;
    forever begin
      @(negedge clk);
      if (clr) begin
        slot_n = 0;
        m_ovr  = 1'b0;
        m_frm  = 1'b0;
        exp_q.delete();
      end
      check("rx_valid", 32'(bus.rx_valid), 32'(slot_n != 0));
      check("overrun",  32'(bus.overrun),  32'(m_ovr));
      check("frm_err",  32'(bus.frm_err),  32'(m_frm));
      if (!clr) begin
        ovr_set = 1'b0;
        if (slot_n != 0 && bus.rx_ready) slot_n--;
        if (deliver_now) begin
          if (slot_n == 0) begin
            slot_n++;
            exp_q.push_back({dlv_perr, dlv_data});
          end else begin
            m_ovr   = 1'b1;
            ovr_set = 1'b1;
          end
        end
        if (bus.ovr_clr && !ovr_set) m_ovr = 1'b0;
        m_frm = frm_now;
      end
    end
  end

  // monitor: every handshake must hand over the oldest accepted word
  initial begin : monitor
    logic [8:0] w;
    forever begin
      @(negedge clk);
      if (!clr && bus.rx_valid && bus.rx_ready) begin
        check("sb_has_word", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("rx_data", 32'(bus.rx_data), 32'(w[7:0]));
          check("par_err", 32'(bus.par_err), 32'(w[8]));
        end
      end
    end
  end

  task automatic bit2(input logic b);
    @(posedge clk);
    #2;
    bus2.sdi = b;
  endtask

  initial begin : stim
    logic [7:0] d;
    logic       pbit;
    logic       stopb;
    logic       prev_bad;
    clr          = 1'b1;
    bus.sdi      = 1'b1;
    bus.rx_ready = 1'b0;
    bus.ovr_clr  = 1'b0;
    bus2.sdi      = 1'b1;
    bus2.rx_ready = 1'b0;
    bus2.ovr_clr  = 1'b0;
    deliver_now  = 1'b0;
    frm_now      = 1'b0;
    dlv_data     = 8'h00;
    dlv_perr     = 1'b0;
    rdy_mode     = 0;
    ovr_rand     = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    check("rst_rx_data", 32'(bus.rx_data), 32'h0);
    check("rst_par_err", 32'(bus.par_err), 32'h0);
    check("rst_busy",    32'(bus.busy),    32'h0);
    clr = 1'b0;
    idle(2, 1'b1);

    // clean word, held with no consumer
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(1, 1'b1);
    check("t1_data", 32'(bus.rx_data),  32'hA5);
    check("t1_perr", 32'(bus.par_err),  32'h0);
    check("t1_vld",  32'(bus.rx_valid), 32'h1);
    drain();

    // wrong parity bit; word stays pending into the framing-error case
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle(1, 1'b1);
    check("t2_data", 32'(bus.rx_data), 32'h3C);
    check("t2_perr", 32'(bus.par_err), 32'h1);

    // bad stop bit, then line held low: no restart until it idles
    send_frame(8'h81, 1'b0, 1'b0, -1);
    idle(1, 1'b0);
    check("t3_frm",  32'(bus.frm_err), 32'h1);
    check("t3_keep", 32'(bus.rx_data), 32'h3C);
    rdy_mode = 1;
    idle(4, 1'b0);
    rdy_mode = 0;
    idle(1, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b1, -1);
    idle(1, 1'b1);
    check("t3_data", 32'(bus.rx_data), 32'h0F);
    drain();

    // back-to-back into a full slot
    send_frame(8'h11, 1'b0, 1'b1, -1);
    send_frame(8'h22, 1'b0, 1'b1, -1);
    idle(1, 1'b1);
    check("t4_data", 32'(bus.rx_data), 32'h11);
    check("t4_ovr",  32'(bus.overrun), 32'h1);
    bit_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, -1, 1'b1);
    idle(1, 1'b1);
    check("t4_ovr_clr", 32'(bus.overrun), 32'h0);
    drain();

    // consume and refill on the same edge
    send_frame(8'h55, 1'b0, 1'b1, -1);
    send_frame(8'hAA, 1'b0, 1'b1, 1);
    idle(1, 1'b1);
    check("t5_vld",  32'(bus.rx_valid), 32'h1);
    check("t5_data", 32'(bus.rx_data),  32'hAA);
    check("t5_ovr",  32'(bus.overrun),  32'h0);
    drain();

    // randomised traffic with random consumer and overrun clears
    rdy_mode = 2;
    ovr_rand = 1'b1;
    prev_bad = 1'b0;
    for (int f = 0; f < 60; f++) begin
      if (prev_bad) idle($urandom_range(1, 3), 1'b1);
      else          idle($urandom_range(0, 2), 1'b1);
      d     = 8'($urandom());
      pbit  = (^d) ^ ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 7) != 0);
      send_frame(d, pbit, stopb, -1);
      prev_bad = ~stopb;
    end
    ovr_rand = 1'b0;
    rdy_mode = 1;
    idle(4, 1'b1);
    rdy_mode = 0;
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a frame with the line low
    send_frame(8'h96, 1'b0, 1'b1, -1);
    bit_cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, -1, 1'b0);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, -1, 1'b0);
    @(posedge clk);
    #2;
    clr      = 1'b1;
    bus.sdi  = 1'b0;
    #1;
    check("t6_rst_data", 32'(bus.rx_data),  32'h0);
    check("t6_rst_vld",  32'(bus.rx_valid), 32'h0);
    check("t6_rst_busy", 32'(bus.busy),     32'h0);
    @(posedge clk);
    #2;
    clr = 1'b0;
    idle(4, 1'b0);
    idle(1, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    idle(1, 1'b1);
    check("t6_data", 32'(bus.rx_data), 32'h5A);
    drain();

    // parity disabled: 10-cycle frames, par_err never set
    bit2(1'b1);
    bit2(1'b0);
    d = 8'hC3;
    for (int i = 7; i >= 0; i--) bit2(d[i]);
    bit2(1'b1);
    check("np_early_vld", 32'(bus2.rx_valid), 32'h0);
    bit2(1'b1);
    check("np_vld",  32'(bus2.rx_valid), 32'h1);
    check("np_data", 32'(bus2.rx_data),  32'hC3);
    check("np_perr", 32'(bus2.par_err),  32'h0);
    bus2.rx_ready = 1'b1;
    bit2(1'b1);
    bus2.rx_ready = 1'b0;
    bit2(1'b0);
    d = 8'h01;
    for (int i = 7; i >= 0; i--) bit2(d[i]);
    bit2(1'b1);
    bit2(1'b1);
    check("np_data2", 32'(bus2.rx_data), 32'h01);
    check("np_perr2", 32'(bus2.par_err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "time limit");
  end

endmodule
